// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - two-stage pipelined RV branch/jump resolution unit
// Define BRANCH_STATS_EN to add saturating branch/taken/mispredict counters.
module branch_unit #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_kind,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
  output logic            out_mispredict,
  output logic            out_illegal
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_mispredict
`endif
);

  typedef enum logic [1:0] {
    KIND_BR   = 2'b00,
    KIND_JAL  = 2'b01,
    KIND_JALR = 2'b10,
    KIND_RSVD = 2'b11
  } kind_e;

  if (XLEN < 4 || STAT_W < 1) begin : g_param_check
    $error("branch_unit: XLEN must be >= 4 and STAT_W >= 1");
  end

  // Stage-0 combinational resolution
  logic            eq, lt_s, lt_u;
  logic [XLEN-1:0] pc_imm, rs1_imm, link_c, target_c;
  logic            taken_c, illegal_c;

  assign eq      = (in_rs1 == in_rs2);
  assign lt_s    = ($signed(in_rs1) < $signed(in_rs2));
  assign lt_u    = (in_rs1 < in_rs2);
  assign pc_imm  = in_pc + in_imm;
  assign rs1_imm = in_rs1 + in_imm;
  assign link_c  = in_pc + XLEN'(4);

  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    target_c  = pc_imm;
    unique case (kind_e'(in_kind))
      KIND_BR: begin
        case (in_funct3)
          3'b000:  taken_c = eq;
          3'b001:  taken_c = !eq;
          3'b100:  taken_c = lt_s;
          3'b101:  taken_c = !lt_s;
          3'b110:  taken_c = lt_u;
          3'b111:  taken_c = !lt_u;
          default: illegal_c = 1'b1;
        endcase
      end
      KIND_JAL: taken_c = 1'b1;
      KIND_JALR: begin
        taken_c  = 1'b1;
        target_c = {rs1_imm[XLEN-1:1], 1'b0};
      end
      KIND_RSVD: illegal_c = 1'b1;
    endcase
  end

  // Pipeline control: S2 drains on consumer accept, S1 follows S2
  logic            s1_valid;
  logic            s1_taken, s1_mispredict, s1_illegal;
  logic [XLEN-1:0] s1_target, s1_link;
  logic            s2_load, s1_load;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_taken      <= 1'b0;
      s1_mispredict <= 1'b0;
      s1_illegal    <= 1'b0;
      s1_target     <= '0;
      s1_link       <= '0;
    end else begin
      if (flush)
        s1_valid <= 1'b0;
      else if (s1_load)
        s1_valid <= in_valid;
      if (s1_load && in_valid) begin
        s1_taken      <= taken_c;
        s1_mispredict <= taken_c ^ in_pred_taken;
        s1_illegal    <= illegal_c;
        s1_target     <= target_c;
        s1_link       <= link_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_mispredict <= 1'b0;
      out_illegal    <= 1'b0;
      out_target     <= '0;
      out_link       <= '0;
    end else begin
      if (flush)
        out_valid <= 1'b0;
      else if (s2_load)
        out_valid <= s1_valid;
      if (s2_load && s1_valid) begin
        out_taken      <= s1_taken;
        out_mispredict <= s1_mispredict;
        out_illegal    <= s1_illegal;
        out_target     <= s1_target;
        out_link       <= s1_link;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  // Branch flag travels with the entry so counting happens at retirement
  logic s1_is_branch, out_is_branch, retire;

  assign retire = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_is_branch  <= 1'b0;
      out_is_branch <= 1'b0;
    end else begin
      if (s1_load && in_valid)
        s1_is_branch <= (in_kind == KIND_BR);
      if (s2_load && s1_valid)
        out_is_branch <= s1_is_branch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches   <= '0;
      stat_taken      <= '0;
      stat_mispredict <= '0;
    end else if (retire) begin
      if (out_is_branch && !(&stat_branches))
        stat_branches <= stat_branches + 1'b1;
      if (out_taken && !(&stat_taken))
        stat_taken <= stat_taken + 1'b1;
      if (out_mispredict && !(&stat_mispredict))
        stat_mispredict <= stat_mispredict + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - directed and randomized self-checking bench for branch_unit
// Checks every cycle against an in-order scoreboard of expected results.
module tb_branch_unit;
  localparam int XLEN   = 32;
  localparam int STAT_W = 3;

  logic            clk = 1'b0;
  logic            rst_n, flush, in_valid, in_ready, in_pred_taken;
  logic [1:0]      in_kind;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1, in_rs2, in_pc, in_imm;
  logic            out_valid, out_ready, out_taken, out_mispredict, out_illegal;
  logic [XLEN-1:0] out_target, out_link;
`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_branches, stat_taken, stat_mispredict;
`endif

  branch_unit #(.XLEN(XLEN), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_pc(in_pc), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_target(out_target), .out_link(out_link),
    .out_mispredict(out_mispredict), .out_illegal(out_illegal)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_taken(stat_taken),
    .stat_mispredict(stat_mispredict)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic            mispredict;
    logic            illegal;
    logic            is_branch;
    int              t;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   st_br = 0, st_tk = 0, st_mp = 0;
  int   stat_max = (1 << STAT_W) - 1;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Architectural meaning of one request, straight from the ISA rules
  function automatic exp_t model(input logic [1:0] kind, input logic [2:0] f3,
                                 input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                                 input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                                 input logic pred);
    exp_t e;
    e.target = pc + imm;
    e.link = pc + 32'd4;
    e.taken = 1'b0;
    e.illegal = 1'b0;
    e.is_branch = (kind == 2'd0);
    e.t = 0;
    if (kind == 2'd0) begin
      if (f3 == 3'd0) e.taken = (rs1 == rs2);
      else if (f3 == 3'd1) e.taken = (rs1 != rs2);
      else if (f3 == 3'd4) e.taken = ($signed(rs1) < $signed(rs2));
      else if (f3 == 3'd5) e.taken = ($signed(rs1) >= $signed(rs2));
      else if (f3 == 3'd6) e.taken = (rs1 < rs2);
      else if (f3 == 3'd7) e.taken = (rs1 >= rs2);
      else e.illegal = 1'b1;
    end else if (kind == 2'd1) begin
      e.taken = 1'b1;
    end else if (kind == 2'd2) begin
      e.taken = 1'b1;
      e.target = (rs1 + imm) & ~32'd1;
    end else begin
      e.illegal = 1'b1;
    end
    e.mispredict = e.taken ^ pred;
    return e;
  endfunction

  // Called at a falling edge with inputs already driven; checks, updates model, advances one cycle
  task automatic tick();
    logic exp_ready, exp_ovalid;
    exp_t e;
    #1;
    exp_ready  = (q.size() < 2) || out_ready;
    exp_ovalid = (q.size() > 0) && (cyc - q[0].t >= 2);
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, exp_ovalid);
    if (exp_ovalid) begin
      chk("out_taken", out_taken, q[0].taken);
      chk("out_target", out_target, q[0].target);
      chk("out_link", out_link, q[0].link);
      chk("out_mispredict", out_mispredict, q[0].mispredict);
      chk("out_illegal", out_illegal, q[0].illegal);
    end
`ifdef BRANCH_STATS_EN
    chk("stat_branches", stat_branches, st_br);
    chk("stat_taken", stat_taken, st_tk);
    chk("stat_mispredict", stat_mispredict, st_mp);
`endif
    if (flush) begin
      q.delete();
    end else begin
      if (exp_ovalid && out_ready) begin
        if (q[0].is_branch && st_br < stat_max) st_br++;
        if (q[0].taken && st_tk < stat_max) st_tk++;
        if (q[0].mispredict && st_mp < stat_max) st_mp++;
        void'(q.pop_front());
      end
      if (in_valid && exp_ready) begin
        e = model(in_kind, in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken);
        e.t = cyc;
        q.push_back(e);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] kind, input logic [2:0] f3,
                       input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                       input logic pred);
    in_valid = 1'b1;
    in_kind = kind;
    in_funct3 = f3;
    in_rs1 = rs1;
    in_rs2 = rs2;
    in_pc = pc;
    in_imm = imm;
    in_pred_taken = pred;
  endtask

  task automatic drive_random();
    logic [XLEN-1:0] a;
    a = $urandom;
    drive(2'($urandom_range(0, 3)), 3'($urandom), a,
          ($urandom_range(0, 3) == 0) ? a : 32'($urandom),
          {$urandom, 2'b00}, $urandom, 1'($urandom));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(2'd0, 3'd0, '0, '0, '0, '0, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_taken", out_taken, 1'b0);
    chk("rst_mispredict", out_mispredict, 1'b0);
    chk("rst_illegal", out_illegal, 1'b0);
    chk("rst_target", out_target, 32'd0);
    chk("rst_link", out_link, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // BLT vs BLTU with the same operands
    drive(2'd0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0); tick();
    in_valid = 1'b0; tick();
    chk("blt_taken", out_taken, 1'b1);
    chk("blt_mispredict", out_mispredict, 1'b1);
    drive(2'd0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0); tick();
    in_valid = 1'b0; tick();
    chk("bltu_taken", out_taken, 1'b0);
    chk("bltu_mispredict", out_mispredict, 1'b0);

    // JALR clears bit 0
    drive(2'd2, 3'd0, 32'h0000_1003, 32'd0, 32'h100, 32'd4, 1'b1); tick();
    in_valid = 1'b0; tick();
    chk("jalr_target", out_target, 32'h0000_1006);
    chk("jalr_link", out_link, 32'h0000_0104);
    chk("jalr_taken", out_taken, 1'b1);

    // Illegal funct3 predicted taken
    drive(2'd0, 3'd2, 32'd7, 32'd7, 32'h300, 32'h10, 1'b1); tick();
    in_valid = 1'b0; tick();
    chk("ill_illegal", out_illegal, 1'b1);
    chk("ill_taken", out_taken, 1'b0);
    chk("ill_mispredict", out_mispredict, 1'b1);

    // Target and link wrap modulo 2^XLEN
    drive(2'd0, 3'd0, 32'd5, 32'd5, 32'hFFFF_FFFC, 32'd8, 1'b1); tick();
    in_valid = 1'b0; tick();
    chk("wrap_target", out_target, 32'h0000_0004);
    chk("wrap_link", out_link, 32'h0000_0000);

    // Back-to-back BEQ/BNE stream, then a 3-cycle consumer stall
    for (int i = 0; i < 12; i++) begin
      drive(2'd0, 3'(i % 2), 32'(i), (i % 3 == 0) ? 32'(i) : 32'(i + 1),
            32'(i * 4), 32'h20, 1'($urandom));
      tick();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      tick();
    end
    chk("stall_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    in_valid = 1'b0;
    repeat (3) tick();

    // Flush with two entries in flight and a same-cycle request
    out_ready = 1'b0;
    drive_random(); tick();
    drive_random(); tick();
    drive_random(); flush = 1'b1; out_ready = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    repeat (3) tick();

    // Randomized traffic with backpressure and occasional flushes
    for (int i = 0; i < 400; i++) begin
      drive_random();
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 24) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    drive_random(); tick();
    drive_random(); tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_target", out_target, 32'd0);
    q.delete();
    st_br = 0; st_tk = 0; st_mp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_random();
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
